// File: rtl/user_glyph_fetcher_pkg.sv
// Shared font-ROM layout constants, fetcher FSM encoding and the OBI manager
// bus types used by the user domain (same layout as croc_pkg MgrObiCfg).
package user_glyph_fetcher_pkg;

  localparam logic [31:0] FontBaseAddr      = 32'h2000_4000;
  localparam int unsigned FontFirstChar     = 32'd32;
  localparam int unsigned FontLastChar      = 32'd126;
  localparam int unsigned FontBytesPerGlyph = 32'd12;
  localparam int unsigned FontSubstChar     = 32'd63;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    mgr_obi_a_chan_t a;
    logic            req;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;

  // Codes outside the mapped range are replaced by the substitute glyph.
  function automatic logic [7:0] effective_code(input logic [7:0]  code,
                                                input int unsigned first,
                                                input int unsigned last,
                                                input int unsigned subst);
    logic [7:0] w_res;
    if ((code >= 8'(first)) && (code <= 8'(last))) begin
      w_res = code;
    end else begin
      w_res = 8'(subst);
    end
    return w_res;
  endfunction

endpackage

// File: rtl/user_glyph_fetcher.sv
// OBI manager that fetches one font glyph byte by byte from the font ROM and
// presents the assembled glyph on a valid/ready output.
module user_glyph_fetcher
  import user_glyph_fetcher_pkg::*;
#(
  parameter logic [31:0] FONT_BASE_ADDR  = FontBaseAddr,
  parameter int unsigned FIRST_CHAR      = FontFirstChar,
  parameter int unsigned LAST_CHAR       = FontLastChar,
  parameter int unsigned BYTES_PER_GLYPH = FontBytesPerGlyph,
  parameter int unsigned SUBST_CHAR      = FontSubstChar
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           char_valid_i,
  output logic                           char_ready_o,
  input  logic [7:0]                     char_i,
  output logic                           glyph_valid_o,
  input  logic                           glyph_ready_i,
  output logic [8*BYTES_PER_GLYPH-1:0]   glyph_o,
  output logic                           glyph_err_o,
  output mgr_obi_req_t                   obi_req_o,
  input  mgr_obi_rsp_t                   obi_rsp_i
);

  localparam int unsigned GlyphW  = 8 * BYTES_PER_GLYPH;
  localparam logic [3:0]  LastIdx = 4'(BYTES_PER_GLYPH - 32'd1);

  logic [1:0]        r_state;
  logic [3:0]        r_idx;
  logic [31:0]       r_base;
  logic [GlyphW-1:0] r_glyph;
  logic              r_err;

  logic [7:0]        w_code;
  logic [31:0]       w_base;
  logic [6:0]        w_bit;
  logic [7:0]        w_rbyte;
  logic              w_unused_rsp;

  assign w_code  = effective_code(char_i, FIRST_CHAR, LAST_CHAR, SUBST_CHAR);
  assign w_base  = FONT_BASE_ADDR + (32'(w_code) - FIRST_CHAR) * BYTES_PER_GLYPH;
  assign w_bit   = {r_idx, 3'b000};
  assign w_rbyte = obi_rsp_i.r.err ? 8'h00 : obi_rsp_i.r.rdata[7:0];
  assign w_unused_rsp = ^{obi_rsp_i.r.rdata[31:8], obi_rsp_i.r.rid};

  // Fetch sequencer: glyph base is resolved once at accept so the request
  // address only needs base + byte index while the bus is active.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_idx   <= 4'd0;
      r_base  <= 32'h0000_0000;
      r_glyph <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (char_valid_i) begin
            r_base  <= w_base;
            r_idx   <= 4'd0;
            r_err   <= 1'b0;
            r_glyph <= '0;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (obi_rsp_i.gnt) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (obi_rsp_i.rvalid) begin
            r_glyph[w_bit +: 8] <= w_rbyte;
            r_err               <= r_err | obi_rsp_i.r.err;
            if (r_idx == LastIdx) begin
              r_state <= ST_DONE;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          if (glyph_ready_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus request decoded purely from registered state; reads a single byte lane.
  always_comb begin
    obi_req_o         = '0;
    obi_req_o.req     = (r_state == ST_REQ);
    obi_req_o.a.addr  = r_base + 32'(r_idx);
    obi_req_o.a.we    = 1'b0;
    obi_req_o.a.be    = 4'b0001;
    obi_req_o.a.wdata = 32'h0000_0000;
    obi_req_o.a.aid   = 1'b0;
  end

  assign char_ready_o  = (r_state == ST_IDLE);
  assign glyph_valid_o = (r_state == ST_DONE);
  assign glyph_o       = r_glyph;
  assign glyph_err_o   = r_err;

endmodule

// File: tb/tb_user_glyph_fetcher.sv
// Directed bench for user_glyph_fetcher with a behavioural font ROM subordinate
// (configurable gnt stall, rvalid delay and error injection per byte).
module tb_user_glyph_fetcher;
  import user_glyph_fetcher_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         char_valid = 1'b0;
  logic [7:0]   char_in = 8'h00;
  logic         glyph_ready = 1'b0;
  logic         char_ready;
  logic         glyph_valid;
  logic [95:0]  glyph;
  logic         glyph_err;
  mgr_obi_req_t obi_req;
  mgr_obi_rsp_t obi_rsp;

  localparam logic [95:0] G_A  = {8'h40, 8'h00, 8'hC0, 8'h01, 8'h00, 8'h0F,
                                  8'h00, 8'h39, 8'hC0, 8'h07, 8'h40, 8'h00};
  localparam logic [95:0] G_B  = {8'h00, 8'h00, 8'h80, 8'h1B, 8'h40, 8'h24,
                                  8'h40, 8'h24, 8'hC0, 8'h3F, 8'h40, 8'h20};
  localparam logic [95:0] G_0  = {8'h00, 8'h00, 8'h80, 8'h1F, 8'h40, 8'h20,
                                  8'h40, 8'h20, 8'h80, 8'h1F, 8'h00, 8'h00};
  localparam logic [95:0] G_0E = {8'h00, 8'h00, 8'h80, 8'h1F, 8'h40, 8'h20,
                                  8'h00, 8'h20, 8'h80, 8'h1F, 8'h00, 8'h00};

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]  rom [0:1139];
  int          hold_byte = -1;
  int          hold_total = 0;
  int          stall_seen = 0;
  int          delay_byte = -1;
  int          delay_cycles = 0;
  int          err_byte = -1;
  int          resp_cnt = 0;
  logic [31:0] resp_addr = 32'h0;
  int          bad_stall = 0;
  int          bad_a = 0;
  logic        prev_stall = 1'b0;
  mgr_obi_a_chan_t prev_a;
  logic [31:0] addr_q [$];
  int          ncyc;

  always #5 clk = ~clk;

  user_glyph_fetcher dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .char_valid_i  (char_valid),
    .char_ready_o  (char_ready),
    .char_i        (char_in),
    .glyph_valid_o (glyph_valid),
    .glyph_ready_i (glyph_ready),
    .glyph_o       (glyph),
    .glyph_err_o   (glyph_err),
    .obi_req_o     (obi_req),
    .obi_rsp_i     (obi_rsp)
  );

  function automatic int byte_of(input logic [31:0] a);
    return int'((a - 32'h2000_4000) % 32'd12);
  endfunction

  function automatic logic [7:0] rom_rd(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h2000_4000;
    if (off < 32'd1140) return rom[int'(off)];
    return 8'hEE;
  endfunction

  // Font ROM subordinate: combinational gnt, response after 1 + delay cycles.
  always_comb begin
    obi_rsp          = '0;
    obi_rsp.gnt      = obi_req.req &&
                       !((byte_of(obi_req.a.addr) == hold_byte) && (stall_seen < hold_total));
    obi_rsp.rvalid   = (resp_cnt == 1);
    obi_rsp.r.rdata  = {24'hA5C3E1, rom_rd(resp_addr)};
    obi_rsp.r.err    = (resp_cnt == 1) && (byte_of(resp_addr) == err_byte);
  end

  // Subordinate state plus bus monitors (transfer log, a-channel stability).
  always @(posedge clk) begin
    if (obi_req.req && obi_rsp.gnt) begin
      resp_cnt  <= 1 + ((byte_of(obi_req.a.addr) == delay_byte) ? delay_cycles : 0);
      resp_addr <= obi_req.a.addr;
      addr_q.push_back(obi_req.a.addr);
      if (obi_req.a.we !== 1'b0 || obi_req.a.be !== 4'b0001 ||
          obi_req.a.wdata !== 32'h0 || obi_req.a.aid !== 1'b0) bad_a <= bad_a + 1;
    end else if (resp_cnt != 0) begin
      resp_cnt <= resp_cnt - 1;
    end
    if (obi_req.req && !obi_rsp.gnt) stall_seen <= stall_seen + 1;
    if (prev_stall && (!obi_req.req || obi_req.a !== prev_a)) bad_stall <= bad_stall + 1;
    prev_stall <= obi_req.req && !obi_rsp.gnt;
    prev_a     <= obi_req.a;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_glyph(input int off, input logic [95:0] g);
    for (int k = 0; k < 12; k++) rom[off + k] = g[8*k +: 8];
  endtask

  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    chk("char_ready_before_req", 96'(char_ready), 96'(1));
    addr_q.delete();
    char_valid = 1'b1;
    char_in    = c;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_in    = 8'h00;
  endtask

  // Returns the cycle number (handshake = cycle 0) in which glyph_valid is seen.
  task automatic wait_valid(output int n);
    n = 1;
    @(negedge clk);
    while (glyph_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic take_glyph(input string tag);
    glyph_ready = 1'b1;
    @(posedge clk);
    #1;
    glyph_ready = 1'b0;
    chk({tag, "_idle_ready"}, 96'(char_ready), 96'(1));
    chk({tag, "_valid_low"}, 96'(glyph_valid), 96'(0));
  endtask

  task automatic check_addrs(input string tag, input logic [31:0] first);
    chk({tag, "_xfers"}, 96'(addr_q.size()), 96'(12));
    if (addr_q.size() == 12) begin
      for (int i = 0; i < 12; i++) chk({tag, "_addr"}, 96'(addr_q[i]), 96'(first + 32'(i)));
    end
  endtask

  initial begin
    for (int i = 0; i < 1140; i++) rom[i] = 8'(i * 37 + 11);
    load_glyph(396, G_A);
    load_glyph(408, G_B);
    load_glyph(192, G_0);
    rom[372] = 8'h18; rom[373] = 8'h00; rom[374] = 8'h20; rom[375] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 96'(obi_req.req), 96'(0));
    chk("rst_char_ready", 96'(char_ready), 96'(1));
    chk("rst_valid", 96'(glyph_valid), 96'(0));
    chk("rst_glyph", glyph, 96'(0));
    chk("rst_err", 96'(glyph_err), 96'(0));
    rst = 1'b0;

    // 'A' with zero-wait ROM
    send_char(8'h41);
    wait_valid(ncyc);
    chk("A_valid_cycle", 96'(ncyc), 96'(25));
    chk("A_glyph", glyph, G_A);
    chk("A_err", 96'(glyph_err), 96'(0));
    check_addrs("A", 32'h2000_418C);
    take_glyph("A");

    // Unmapped codes fetch '?'
    send_char(8'h7F);
    wait_valid(ncyc);
    check_addrs("u7F", 32'h2000_4174);
    chk("u7F_glyph_lo", 96'(glyph[31:0]), 96'(32'h0020_0018));
    take_glyph("u7F");
    send_char(8'h05);
    wait_valid(ncyc);
    check_addrs("u05", 32'h2000_4174);
    chk("u05_glyph_lo", 96'(glyph[31:0]), 96'(32'h0020_0018));
    chk("u05_err", 96'(glyph_err), 96'(0));
    take_glyph("u05");

    // gnt withheld 3 cycles on byte 4
    hold_byte  = 4;
    hold_total = 3;
    send_char(8'h41);
    wait_valid(ncyc);
    chk("stall_valid_cycle", 96'(ncyc), 96'(28));
    chk("stall_stable", 96'(bad_stall), 96'(0));
    chk("stall_cycles", 96'(stall_seen), 96'(3));
    chk("stall_xfers", 96'(addr_q.size()), 96'(12));
    chk("stall_glyph", glyph, G_A);
    take_glyph("stall");
    hold_byte = -1;

    // r.err on byte 5 of '0'
    err_byte = 5;
    send_char(8'h30);
    wait_valid(ncyc);
    chk("err_valid_cycle", 96'(ncyc), 96'(25));
    chk("err_glyph", glyph, G_0E);
    chk("err_flag", 96'(glyph_err), 96'(1));
    take_glyph("err");
    err_byte = -1;

    // Clean glyph after error, then 10 cycles of back-pressure
    send_char(8'h41);
    wait_valid(ncyc);
    chk("clean_err", 96'(glyph_err), 96'(0));
    chk("clean_glyph", glyph, G_A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_glyph", glyph, G_A);
      chk("bp_valid", 96'(glyph_valid), 96'(1));
      chk("bp_char_ready", 96'(char_ready), 96'(0));
      chk("bp_req", 96'(obi_req.req), 96'(0));
    end
    take_glyph("bp");

    // Reset pulse during WAIT of byte 6, response delayed past the reset
    delay_byte   = 6;
    delay_cycles = 4;
    send_char(8'h41);
    repeat (13) @(posedge clk);
    #3;
    chk("mid_partial_glyph", 96'(glyph[47:0]), 96'(G_A[47:0]));
    rst = 1'b1;
    #1;
    chk("arst_req", 96'(obi_req.req), 96'(0));
    chk("arst_valid", 96'(glyph_valid), 96'(0));
    chk("arst_glyph", glyph, 96'(0));
    chk("arst_err", 96'(glyph_err), 96'(0));
    chk("arst_char_ready", 96'(char_ready), 96'(1));
    @(negedge clk);
    rst = 1'b0;
    ncyc = 0;
    while (obi_rsp.rvalid !== 1'b1 && ncyc < 20) begin
      @(negedge clk);
      ncyc++;
    end
    chk("late_rvalid_ready", 96'(char_ready), 96'(1));
    chk("late_rvalid_glyph", glyph, 96'(0));
    @(negedge clk);
    chk("after_late_glyph", glyph, 96'(0));
    chk("after_late_valid", 96'(glyph_valid), 96'(0));
    chk("after_late_req", 96'(obi_req.req), 96'(0));
    delay_byte = -1;

    send_char(8'h42);
    wait_valid(ncyc);
    chk("B_valid_cycle", 96'(ncyc), 96'(25));
    chk("B_glyph", glyph, G_B);
    chk("B_err", 96'(glyph_err), 96'(0));
    check_addrs("B", 32'h2000_4198);
    take_glyph("B");
    chk("a_channel_fields", 96'(bad_a), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
